reg_file_sb: RTL

Parametrised register file for the MIPS datapath, the successor of the fixed 32x32 two-read/one-write file. It adds asynchronous clear, a hardwired zero register, write-to-read bypass and a per-register pending scoreboard for multi-cycle writebacks (loads, multiply/divide). It sits between decode (reads, scoreboard set) and writeback (write port).

---
 rtl/reg_file_sb.sv | 83 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional hardwired
// zero register and a per-register pending scoreboard for multi-cycle writebacks.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic wr_ok;
    logic set_ok;
    logic hit1;
    logic hit2;

    // Register 0 swallows writes and sets when it is hardwired to zero.
    assign wr_ok  = we     && !(ZERO_REG && (wa == '0));
    assign set_ok = set_en && !(ZERO_REG && (set_addr == '0));

    // NOTE: the whole array is cleared by reset, so it is built from flops rather
    // than an SRAM macro; a datapath register file must read 0 after clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the
            // pre-edge values, so write and scoreboard logic cannot race.
            if (wr_ok) begin
                mem[wa] <= wd;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (set_ok && (set_addr == ADDR_W'(i))) begin
                    pend[i] <= 1'b1;
                end else if (wr_ok && (wa == ADDR_W'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign hit1 = wr_ok && (wa == ra1);
    assign hit2 = wr_ok && (wa == ra2);

    assign rd1 = rst                        ? '0  :
                 hit1                       ? wd  :
                 (ZERO_REG && (ra1 == '0))  ? '0  : mem[ra1];
    assign rd2 = rst                        ? '0  :
                 hit2                       ? wd  :
                 (ZERO_REG && (ra2 == '0))  ? '0  : mem[ra2];

    // A writeback in flight satisfies the reader through the bypass, so it is not busy.
    assign busy1 = !rst && pend[ra1] && !(we && (wa == ra1));
    assign busy2 = !rst && pend[ra2] && !(we && (wa == ra2));

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + (ADDR_W + 1)'(pend[i]);
        end
    end

endmodule
